spi_flash_sched: RTL and testbench

SPI_FLASH_SCHED -- requirements
Module: spi_flash_sched

---
 rtl/spi_flash_pkg.sv | 24 ++
 rtl/spi_slot_timer.sv | 36 +++
 rtl/spi_flash_sched.sv | 152 +++++++++++++++
 tb/tb_spi_flash_sched.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_flash_pkg.sv
// Shared types and constants for the two-requester SPI flash scheduler.
package spi_flash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DATA,
    ST_DONE
  } state_t;

  localparam logic [7:0] CMD_READ_DFLT  = 8'h03;
  localparam logic [7:0] CMD_WRITE_DFLT = 8'h02;
  localparam int         ADDR_BYTES     = 3;
  localparam int         DATA_BYTES     = 4;

  // Byte k of an nbytes-wide word, counting from the most significant byte.
  function automatic logic [7:0] msb_byte(input logic [31:0] w, input int nbytes, input int k);
    logic [31:0] s;
    s = w >> (8 * (nbytes - 1 - k));
    return s[7:0];
  endfunction

endpackage

// File: rtl/spi_slot_timer.sv
// Divides p_clk into DIV-cycle SPI byte slots and produces the per-slot strobes.
module spi_slot_timer #(
  parameter int DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_run,
  output logic o_sclk,
  output logic o_slot_start,
  output logic o_sample,
  output logic o_slot_end
);

  localparam int            CW   = $clog2(DIV);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || !i_run) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // The counter idles at 0, so the first active cycle is already count 0.
  assign o_sclk       = i_run && (r_cnt >= HALF);
  assign o_slot_start = i_run && (r_cnt == '0);
  assign o_sample     = i_run && (r_cnt == HALF);
  assign o_slot_end   = i_run && (r_cnt == LAST);

endmodule

// File: rtl/spi_flash_sched.sv
// Round-robin scheduler granting two requesters access to a byte-wide SPI flash
// for single 32-bit read or write transactions (CMD, 3 address bytes, 4 data bytes).
module spi_flash_sched
  import spi_flash_pkg::*;
#(
  parameter int         DIV       = 4,
  parameter logic [7:0] CMD_READ  = CMD_READ_DFLT,
  parameter logic [7:0] CMD_WRITE = CMD_WRITE_DFLT
) (
  input  logic        p_clk,
  input  logic        p_reset,
  input  logic        m0_req,
  input  logic        m0_write,
  input  logic [23:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_done,
  input  logic        m1_req,
  input  logic        m1_write,
  input  logic [23:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_done,
  output logic        busy,
  output logic        s_css,
  output logic        s_clk,
  output logic [7:0]  s_mosi,
  input  logic [7:0]  s_miso
);

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_slot;
  logic        r_last;
  logic        r_who;
  logic        r_wr;
  logic [23:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_shift;
  logic        w_run;
  logic        w_slot_start;
  logic        w_sample;
  logic        w_slot_end;
  logic        w_grant;
  logic        w_win1;
  logic        w_enter_done;

  // m1 wins outright when alone, and on a tie only if m0 was granted last.
  assign w_win1       = m1_req & (~m0_req | ~r_last);
  assign w_grant      = (r_state == ST_IDLE) & (m0_req | m1_req);
  assign w_enter_done = (r_state == ST_DATA) && (w_next == ST_DONE);

  spi_slot_timer #(
    .DIV(DIV)
  ) u_timer (
    .i_clk       (p_clk),
    .i_rst       (p_reset),
    .i_run       (w_run),
    .o_sclk      (s_clk),
    .o_slot_start(w_slot_start),
    .o_sample    (w_sample),
    .o_slot_end  (w_slot_end)
  );

  always_ff @(posedge p_clk) begin
    if (p_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_grant) w_next = ST_CMD;
      ST_CMD:  if (w_slot_end) w_next = ST_ADDR;
      ST_ADDR: if (w_slot_end && r_slot == 2'(ADDR_BYTES - 1)) w_next = ST_DATA;
      ST_DATA: if (w_slot_end && r_slot == 2'(DATA_BYTES - 1)) w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_run  = 1'b0;
    busy   = 1'b1;
    s_css  = 1'b1;
    s_mosi = 8'h00;
    case (r_state)
      ST_IDLE: busy = 1'b0;
      ST_CMD: begin
        w_run  = 1'b1;
        s_css  = 1'b0;
        s_mosi = r_wr ? CMD_WRITE : CMD_READ;
      end
      ST_ADDR: begin
        w_run  = 1'b1;
        s_css  = 1'b0;
        s_mosi = msb_byte({8'h00, r_addr}, ADDR_BYTES, int'(r_slot));
      end
      ST_DATA: begin
        w_run  = 1'b1;
        s_css  = 1'b0;
        s_mosi = r_wr ? msb_byte(r_wdata, DATA_BYTES, int'(r_slot)) : 8'h00;
      end
      default: ;
    endcase
  end

  always_ff @(posedge p_clk) begin
    if (p_reset) begin
      r_slot   <= '0;
      r_last   <= 1'b1;
      r_who    <= 1'b0;
      r_wr     <= 1'b0;
      m0_done  <= 1'b0;
      m1_done  <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else begin
      m0_done <= w_enter_done & ~r_who;
      m1_done <= w_enter_done & r_who;
      if (w_slot_end) begin
        r_slot <= (w_next != r_state) ? 2'd0 : r_slot + 2'd1;
      end
      if (w_grant) begin
        r_who  <= w_win1;
        r_last <= w_win1;
        r_wr   <= w_win1 ? m1_write : m0_write;
      end
      if (w_enter_done && !r_wr) begin
        if (r_who) m1_rdata <= r_shift;
        else       m0_rdata <= r_shift;
      end
    end
  end

  // Transaction operands are frozen at grant; requester inputs are ignored afterwards.
  always_ff @(posedge p_clk) begin
    if (w_grant) begin
      r_addr  <= w_win1 ? m1_addr : m0_addr;
      r_wdata <= w_win1 ? m1_wdata : m0_wdata;
    end
    if (w_slot_start && r_state == ST_CMD) begin
      r_shift <= '0;
    end else if (w_sample && r_state == ST_DATA) begin
      r_shift <= {r_shift[23:0], s_miso};
    end
  end

endmodule

// File: tb/tb_spi_flash_sched.sv
// Bench for spi_flash_sched: transaction-level reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_spi_flash_sched;

  localparam int DIV = 4;
  localparam int TX  = 8 * DIV + 1;

  logic        p_clk = 1'b0;
  logic        p_reset = 1'b1;
  logic        m0_req = 1'b0, m0_write = 1'b0, m1_req = 1'b0, m1_write = 1'b0;
  logic [23:0] m0_addr = '0, m1_addr = '0;
  logic [31:0] m0_wdata = '0, m1_wdata = '0;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_done, m1_done, busy, s_css, s_clk;
  logic [7:0]  s_mosi;
  logic [7:0]  s_miso = 8'h00;

  always #5 p_clk = ~p_clk;

  spi_flash_sched #(.DIV(DIV)) dut (
    .p_clk(p_clk), .p_reset(p_reset),
    .m0_req(m0_req), .m0_write(m0_write), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_done(m0_done),
    .m1_req(m1_req), .m1_write(m1_write), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_done(m1_done),
    .busy(busy), .s_css(s_css), .s_clk(s_clk), .s_mosi(s_mosi), .s_miso(s_miso)
  );

  int n_pass = 0, n_total = 0;
  int cyc = 0;

  always @(posedge p_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model state
  bit          rst_pend = 1'b1, armed = 1'b0, gnt_pend = 1'b0, act = 1'b0;
  int          t = 0;
  bit          who = 1'b0, wr = 1'b0, last = 1'b1;
  logic [23:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rd [2];
  logic [31:0] flash = '0;
  int          grant_cyc[$];
  bit          who_q[$];
  logic [7:0]  mosi_log[$];
  int          css_low = 0;

  function automatic logic [7:0] frame_byte(input bit w, input logic [23:0] a,
                                            input logic [31:0] d, input int k);
    logic [63:0] f;
    f = {(w ? 8'h02 : 8'h03), a, (w ? d : 32'h0)};
    f = f >> (56 - 8 * k);
    return f[7:0];
  endfunction

  int          slot, cnt;
  bit          e_css, e_clk, e_busy, e_d0, e_d1;
  logic [31:0] tmp;
  logic [7:0]  miso_v;

  always @(negedge p_clk) begin
    if (rst_pend) begin
      act = 1'b0; t = 0; gnt_pend = 1'b0; last = 1'b1;
      rd[0] = '0; rd[1] = '0; armed = 1'b1;
    end else if (gnt_pend) begin
      act = 1'b1; t = 1; gnt_pend = 1'b0;
    end else if (act) begin
      t++;
      if (t > TX) begin act = 1'b0; t = 0; end
    end
    e_css = 1'b1; e_clk = 1'b0; e_busy = act; e_d0 = 1'b0; e_d1 = 1'b0;
    miso_v = 8'h00;
    if (act && t <= 8 * DIV) begin
      slot  = (t - 1) / DIV;
      cnt   = (t - 1) % DIV;
      e_css = 1'b0;
      e_clk = (cnt >= DIV / 2);
      if (slot >= 4) begin
        tmp    = flash >> (8 * (7 - slot));
        miso_v = tmp[7:0];
      end
      chk("s_mosi", s_mosi, frame_byte(wr, addr, wdata, slot));
      if (cnt == 0) mosi_log.push_back(s_mosi);
    end
    if (act && t == TX) begin
      if (!wr) rd[who] = flash;
      if (who) e_d1 = 1'b1; else e_d0 = 1'b1;
    end
    s_miso = miso_v;
    if (armed) begin
      chk("busy", busy, e_busy);
      chk("s_css", s_css, e_css);
      chk("s_clk", s_clk, e_clk);
      chk("m0_done", m0_done, e_d0);
      chk("m1_done", m1_done, e_d1);
      chk("m0_rdata", m0_rdata, rd[0]);
      chk("m1_rdata", m1_rdata, rd[1]);
      if (rst_pend) chk("s_mosi_rst", s_mosi, 8'h00);
      if (!s_css) css_low++;
    end
    rst_pend = p_reset;
    if (!p_reset && !act && (m0_req || m1_req)) begin
      gnt_pend = 1'b1;
      who   = m1_req && (!m0_req || !last);
      last  = who;
      wr    = who ? m1_write : m0_write;
      addr  = who ? m1_addr : m0_addr;
      wdata = who ? m1_wdata : m0_wdata;
      grant_cyc.push_back(cyc);
      who_q.push_back(who);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge p_clk);
    #1;
  endtask

  task automatic wait_done(input bit m, output int at);
    at = -1;
    for (int i = 0; i < 3 * TX && at < 0; i++) begin
      @(negedge p_clk);
      #1;
      if (m ? m1_done : m0_done) at = cyc;
    end
    chk("done_seen", (at >= 0), 1'b1);
    @(posedge p_clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_pass %0d n_total %0d", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  initial begin
    int         at, gi, lb, cb, seen;
    logic [7:0] exp1 [8];
    logic [7:0] exp2 [8];
    exp1 = '{8'h03, 8'h12, 8'h34, 8'h56, 8'h00, 8'h00, 8'h00, 8'h00};
    exp2 = '{8'h02, 8'h00, 8'h00, 8'h10, 8'hCA, 8'hFE, 8'hF0, 8'h0D};

    p_reset = 1'b1;
    tick(2);
    chk("rst_css", s_css, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sclk", s_clk, 1'b0);
    chk("rst_mosi", s_mosi, 8'h00);
    chk("rst_rdata0", m0_rdata, 32'h0);
    p_reset = 1'b0;
    tick(1);

    // m0 read
    flash = 32'hDEADBEEF; m0_addr = 24'h123456; m0_write = 1'b0;
    gi = grant_cyc.size(); lb = mosi_log.size(); cb = css_low;
    m0_req = 1'b1;
    wait_done(1'b0, at);
    m0_req = 1'b0;
    chk("t1_latency", at - grant_cyc[gi], 33);
    chk("t1_rdata", m0_rdata, 32'hDEADBEEF);
    for (int i = 0; i < 8; i++) chk("t1_mosi", mosi_log[lb + i], exp1[i]);
    chk("t1_css_low", css_low - cb, 32);
    tick(2);

    // m1 write, inputs disturbed after grant
    flash = 32'h11223344; m1_addr = 24'h000010; m1_wdata = 32'hCAFEF00D; m1_write = 1'b1;
    lb = mosi_log.size(); cb = css_low;
    m1_req = 1'b1;
    tick(3);
    m1_addr = 24'hFFFFFF; m1_wdata = 32'h0; m1_write = 1'b0;
    wait_done(1'b1, at);
    m1_req = 1'b0;
    for (int i = 0; i < 8; i++) chk("t2_mosi", mosi_log[lb + i], exp2[i]);
    chk("t2_rdata_hold", m1_rdata, 32'h0);
    chk("t2_css_low", css_low - cb, 32);
    tick(2);

    // round-robin after reset
    p_reset = 1'b1;
    tick(1);
    p_reset = 1'b0;
    flash = 32'h0BADF00D; m0_addr = 24'hABCDEF; m1_addr = 24'h000100;
    m0_write = 1'b0; m1_write = 1'b0;
    gi = who_q.size();
    m0_req = 1'b1; m1_req = 1'b1;
    wait_done(1'b0, at);
    chk("t3_rdata0", m0_rdata, 32'h0BADF00D);
    m0_req = 1'b0;
    tick(1);
    m0_req = 1'b1;
    wait_done(1'b1, at);
    m1_req = 1'b0;
    wait_done(1'b0, at);
    m0_req = 1'b0;
    tick(2);
    m0_req = 1'b1; m1_req = 1'b1;
    wait_done(1'b1, at);
    m1_req = 1'b0;
    wait_done(1'b0, at);
    m0_req = 1'b0;
    chk("t3_grants", who_q.size() - gi, 5);
    chk("t3_order0", who_q[gi + 0], 1'b0);
    chk("t3_order1", who_q[gi + 1], 1'b1);
    chk("t3_order2", who_q[gi + 2], 1'b0);
    chk("t3_order3", who_q[gi + 3], 1'b1);
    tick(2);

    // reset during the second address slot
    m0_write = 1'b1; m0_addr = 24'h0A0B0C; m0_wdata = 32'h01020304;
    m0_req = 1'b1;
    tick(9);
    p_reset = 1'b1; m0_req = 1'b0;
    tick(1);
    chk("t4_css", s_css, 1'b1);
    chk("t4_busy", busy, 1'b0);
    chk("t4_sclk", s_clk, 1'b0);
    chk("t4_rdata0", m0_rdata, 32'h0);
    p_reset = 1'b0;
    seen = 0;
    repeat (40) begin
      @(negedge p_clk);
      #1;
      seen += int'(m0_done);
    end
    tick(1);
    chk("t4_no_done", seen, 0);
    flash = 32'h5A5AA5A5; m1_addr = 24'h00ABCD; m1_write = 1'b0;
    lb = mosi_log.size();
    m1_req = 1'b1;
    wait_done(1'b1, at);
    m1_req = 1'b0;
    chk("t4_first_byte", mosi_log[lb], 8'h03);
    chk("t4_rdata1", m1_rdata, 32'h5A5AA5A5);
    tick(2);

    // m1 drops req during DATA; m0 waits
    flash = 32'h13579BDF; m1_addr = 24'h777777; m1_write = 1'b0;
    m1_req = 1'b1;
    tick(20);
    m1_req = 1'b0;
    m0_write = 1'b1; m0_addr = 24'h000020; m0_wdata = 32'h89ABCDEF;
    m0_req = 1'b1;
    wait_done(1'b1, at);
    chk("t5_done_once", m1_done, 1'b0);
    chk("t5_idle_gap", busy, 1'b0);
    tick(1);
    chk("t5_m0_css", s_css, 1'b0);
    chk("t5_m0_busy", busy, 1'b1);
    chk("t5_rdata1", m1_rdata, 32'h13579BDF);
    wait_done(1'b0, at);
    m0_req = 1'b0;
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
